reset_switch_ctrl: RTL and testbench

RESET_SWITCH_CTRL -- requirements
Module: reset_switch_ctrl

---
 rtl/rst_ctrl_pkg.sv | 35 +++
 rtl/rst_cycle_counter.sv | 27 ++
 rtl/reset_switch_ctrl.sv | 127 ++++++++++++
 tb/tb_reset_switch_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rst_ctrl_pkg.sv
// Shared definitions for the reset source switch controller:
// state encoding, counter width, parameter defaults and the registered output bundle.
package rst_ctrl_pkg;

    localparam int          CNT_W                 = 8;
    localparam int unsigned DEFAULT_SETTLE_CYCLES = 2;
    localparam int unsigned DEFAULT_HOLD_CYCLES   = 8;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ASSERT = 3'd2,
        ST_SWITCH = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    typedef struct packed {
        logic select;
        logic select_enable;
        logic force_rst;
        logic cur_sel;
        logic req_ready;
        logic busy;
    } ctrl_out_t;

    localparam ctrl_out_t RESET_OUT = '{
        select:        1'b0,
        select_enable: 1'b0,
        force_rst:     1'b1,
        cur_sel:       1'b0,
        req_ready:     1'b0,
        busy:          1'b1
    };

endpackage

// File: rtl/rst_cycle_counter.sv
// Down-counter that times the ASSERT and HOLD phases: loaded with N-1 on
// state entry, counts down and parks at zero.
module rst_cycle_counter
    import rst_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (!zero) begin
            value <= value - CNT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/reset_switch_ctrl.sv
// Glitch-safe reset source switch: holds the target domain in reset around a
// one-cycle select strobe. Every output is a flop loaded from the next-state decode.
module reset_switch_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEFAULT_HOLD_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ_VALID,
    input  logic REQ_SEL,
    output logic REQ_READY,
    output logic SELECT,
    output logic SELECT_ENABLE,
    output logic FORCE_RST,
    output logic CUR_SEL,
    output logic BUSY
);

    state_t           state;
    state_t           next_state;
    ctrl_out_t        out_d;
    ctrl_out_t        out_q;
    logic             target;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;

    assign accept = REQ_VALID && out_q.req_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            target <= 1'b0;
        end else if (accept && (REQ_SEL != out_q.cur_sel)) begin
            target <= REQ_SEL;
        end
    end

    // INIT is entered with the strobe low (reset value); it leaves only once its strobe cycle has been shown.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_INIT:   if (out_q.select_enable) next_state = ST_IDLE;
            ST_IDLE:   if (accept && (REQ_SEL != out_q.cur_sel)) next_state = ST_ASSERT;
            ST_ASSERT: if (cnt_zero) next_state = ST_SWITCH;
            ST_SWITCH: next_state = ST_HOLD;
            ST_HOLD:   if (cnt_zero) next_state = ST_IDLE;
            default:   next_state = ST_INIT;
        endcase
    end

    always_comb begin
        cnt_load       = (next_state != state);
        cnt_load_value = '0;
        if (next_state == ST_ASSERT) begin
            cnt_load_value = CNT_W'(SETTLE_CYCLES - 1);
        end else if (next_state == ST_HOLD) begin
            cnt_load_value = CNT_W'(HOLD_CYCLES - 1);
        end
    end

    rst_cycle_counter u_counter (
        .CLK        (CLK),
        .RST        (RST),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    // NOTE: every field gets a default before the case, so no path leaves a latch behind.
    always_comb begin
        out_d.select        = out_q.select;
        out_d.select_enable = 1'b0;
        out_d.force_rst     = 1'b1;
        out_d.cur_sel       = out_q.cur_sel;
        out_d.req_ready     = 1'b0;
        out_d.busy          = 1'b1;
        unique case (next_state)
            ST_INIT: begin
                out_d.select        = 1'b0;
                out_d.select_enable = 1'b1;
                out_d.cur_sel       = 1'b0;
            end
            ST_IDLE: begin
                out_d.force_rst = 1'b0;
                out_d.req_ready = 1'b1;
                out_d.busy      = 1'b0;
            end
            ST_SWITCH: begin
                out_d.select        = target;
                out_d.select_enable = 1'b1;
            end
            ST_HOLD: begin
                if (state == ST_SWITCH) out_d.cur_sel = target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q <= RESET_OUT;
        end else begin
            out_q <= out_d;
        end
    end

    assign REQ_READY     = out_q.req_ready;
    assign SELECT        = out_q.select;
    assign SELECT_ENABLE = out_q.select_enable;
    assign FORCE_RST     = out_q.force_rst;
    assign CUR_SEL       = out_q.cur_sel;
    assign BUSY          = out_q.busy;

endmodule

// File: tb/tb_reset_switch_ctrl.sv
// Scoreboard bench for reset_switch_ctrl: two instances (default timing and 1/1 timing)
// share one stimulus stream and are each checked against a timeline model.
module tb_reset_switch_ctrl;

    typedef struct packed {
        logic select;
        logic sel_en;
        logic force_rst;
        logic cur_sel;
        logic ready;
        logic busy;
    } exp_t;

    logic CLK;
    logic RST;
    logic REQ_VALID;
    logic REQ_SEL;

    int n_checks = 0;
    int n_fail   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned S = (g == 0) ? 2 : 1;
        localparam int unsigned H = (g == 0) ? 8 : 1;

        logic ready, select, sel_en, force_rst, cur_sel, busy;

        reset_switch_ctrl #(
            .SETTLE_CYCLES (S),
            .HOLD_CYCLES   (H)
        ) dut (
            .CLK           (CLK),
            .RST           (RST),
            .REQ_VALID     (REQ_VALID),
            .REQ_SEL       (REQ_SEL),
            .REQ_READY     (ready),
            .SELECT        (select),
            .SELECT_ENABLE (sel_en),
            .FORCE_RST     (force_rst),
            .CUR_SEL       (cur_sel),
            .BUSY          (busy)
        );

        // Model: a plan of future cycle outputs; a switch expands into S settle cycles,
        // one strobe cycle and H hold cycles. The scoreboard gets one entry per edge.
        exp_t plan[$];
        exp_t sb[$];
        exp_t last_exp = '0;
        logic m_cur    = 1'b0;

        always @(posedge CLK) begin
            exp_t e;
            if (RST) begin
                plan.delete();
                plan.push_back('{select: 1'b0, sel_en: 1'b1, force_rst: 1'b1,
                                 cur_sel: 1'b0, ready: 1'b0, busy: 1'b1});
                m_cur = 1'b0;
                e = '{select: 1'b0, sel_en: 1'b0, force_rst: 1'b1,
                      cur_sel: 1'b0, ready: 1'b0, busy: 1'b1};
            end else if (plan.size() != 0) begin
                e = plan.pop_front();
            end else begin
                e = '{select: m_cur, sel_en: 1'b0, force_rst: 1'b0,
                      cur_sel: m_cur, ready: 1'b1, busy: 1'b0};
                if (last_exp.ready && REQ_VALID && (REQ_SEL != m_cur)) begin
                    for (int i = 0; i < S; i++)
                        plan.push_back('{select: m_cur, sel_en: 1'b0, force_rst: 1'b1,
                                         cur_sel: m_cur, ready: 1'b0, busy: 1'b1});
                    plan.push_back('{select: REQ_SEL, sel_en: 1'b1, force_rst: 1'b1,
                                     cur_sel: m_cur, ready: 1'b0, busy: 1'b1});
                    for (int i = 0; i < H; i++)
                        plan.push_back('{select: REQ_SEL, sel_en: 1'b0, force_rst: 1'b1,
                                         cur_sel: REQ_SEL, ready: 1'b0, busy: 1'b1});
                    m_cur = REQ_SEL;
                    e = plan.pop_front();
                end
            end
            last_exp = e;
            sb.push_back(e);
        end

        // Monitor: compares every presented output cycle and measures each switch's reset pulse.
        int   run_len = 0;
        bit   run_ok  = 1'b0;
        logic prev_f  = 1'b1;

        always @(negedge CLK) begin
            exp_t e;
            exp_t a;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                a = '{select: select, sel_en: sel_en, force_rst: force_rst,
                      cur_sel: cur_sel, ready: ready, busy: busy};
                check($sformatf("inst%0d outputs{sel,en,frc,cur,rdy,bsy}", g), 32'(a), 32'(e));
            end
            if (RST) begin
                run_ok  = 1'b0;
                run_len = 0;
                prev_f  = 1'b1;
            end else begin
                if (force_rst && !prev_f) begin
                    run_ok  = 1'b1;
                    run_len = 1;
                end else if (force_rst) begin
                    run_len++;
                end else if (prev_f && run_ok) begin
                    check($sformatf("inst%0d force_rst pulse length", g), 32'(run_len), 32'(S + 1 + H));
                end
                if (!force_rst) run_ok = 1'b0;
                prev_f = force_rst;
            end
        end
    end

    initial begin
        RST = 1'b1; REQ_VALID = 1'b0; REQ_SEL = 1'b0;
        repeat (3) @(negedge CLK);
        #1 RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Request for the already committed source: accepted, nothing happens.
        REQ_VALID = 1'b1; REQ_SEL = 1'b0;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        repeat (3) @(negedge CLK);

        // Switch to A, then keep REQ_VALID high while REQ_SEL toggles.
        REQ_VALID = 1'b1; REQ_SEL = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            REQ_SEL = ~REQ_SEL;
        end
        REQ_VALID = 1'b0;
        repeat (20) @(negedge CLK);

        // Start from a known source, then reset in the 5th HOLD cycle of the default instance.
        #1 RST = 1'b1;
        @(negedge CLK);
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        REQ_VALID = 1'b1; REQ_SEL = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        repeat (7) @(negedge CLK);
        check("inst0 select before mid-hold reset", 32'(g_inst[0].select), 32'd1);
        #1 RST = 1'b1;
        #1;
        check("inst0 outputs immediately in reset", 32'({g_inst[0].select, g_inst[0].sel_en,
              g_inst[0].force_rst, g_inst[0].cur_sel, g_inst[0].ready, g_inst[0].busy}), 32'b001001);
        check("inst1 outputs immediately in reset", 32'({g_inst[1].select, g_inst[1].sel_en,
              g_inst[1].force_rst, g_inst[1].cur_sel, g_inst[1].ready, g_inst[1].busy}), 32'b001001);
        repeat (2) @(negedge CLK);
        #1 RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Back-to-back alternating requests, steered by the short instance's committed source.
        REQ_VALID = 1'b1;
        repeat (30) begin
            REQ_SEL = ~g_inst[1].m_cur;
            @(negedge CLK);
        end
        REQ_VALID = 1'b0;
        repeat (20) @(negedge CLK);

        // Random traffic with occasional resets.
        repeat (400) begin
            @(negedge CLK);
            REQ_VALID = ($urandom_range(0, 2) == 0);
            REQ_SEL   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                #1 RST = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge CLK);
                #1 RST = 1'b0;
            end
        end
        REQ_VALID = 1'b0;
        repeat (20) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
